async_fifo: RTL and testbench

- Gray-pointer FIFO, DEPTH = 2**ASIZE words of DSIZE bits, with a write port (winc/wdata/wfull) and a read port (rinc/rdata/rempty).
- Structured as a classic async FIFO: binary plus Gray pointers, and pointer synchronizers between the sides.
- For this block both sides run on one clock, so the synchronizers act as a fixed latency pipeline.
- Sits between a producer and a consumer; status flags are conservative, so neither side can overflow or underflow.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_ptr_sync.sv | 32 +++
 rtl/async_fifo.sv | 98 +++++++++
 tb/tb_async_fifo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and Gray-code helpers for the Gray-pointer FIFO.
package fifo_pkg;

    localparam int DSIZE_DEF       = 8;
    localparam int ASIZE_DEF       = 3;
    localparam int SYNC_STAGES_DEF = 2;

    // Helpers work on a fixed wide vector; callers size-cast in and out.
    localparam int PTR_MAX = 32;

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray);
        logic [PTR_MAX-1:0] bin;
        bin = gray;
        for (int s = 1; s < PTR_MAX; s = s * 2) begin
            bin = bin ^ (bin >> s);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Register pipeline that carries a Gray pointer across to the opposite FIFO side.
module fifo_ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Fewer than two stages would break the crossing latency the flags rely on.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [WIDTH-1:0] pipe [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < N; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[N-1];

endmodule

// File: rtl/async_fifo.sv
// Gray-pointer FIFO with show-ahead read data and conservative registered flags.
module async_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE       = DSIZE_DEF,
    parameter int ASIZE       = ASIZE_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int PW    = ASIZE + 1;

    logic [DSIZE-1:0] mem [DEPTH];

    logic [PW-1:0] wbin, wgray, wbin_next, wgray_next;
    logic [PW-1:0] rbin, rgray, rbin_next, rgray_next;
    logic [PW-1:0] wq_rptr, rq_wptr;
    logic [ASIZE-1:0] waddr, raddr;
    logic wen, ren;
    logic wfull_next, rempty_next;

    // Write side: advance only when not full; full when the next write
    // pointer has lapped the synchronized read pointer by exactly DEPTH.
    assign wen        = winc & ~wfull;
    assign wbin_next  = wbin + PW'(wen);
    assign wgray_next = PW'(bin2gray(PTR_MAX'(wbin_next)));
    assign waddr      = wbin[ASIZE-1:0];
    assign wfull_next = (wgray_next == {~wq_rptr[ASIZE:ASIZE-1], wq_rptr[ASIZE-2:0]});

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin  <= '0;
            wgray <= '0;
            wfull <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wgray <= wgray_next;
            wfull <= wfull_next;
        end
    end

    always_ff @(posedge wclk) begin
        if (wen && !wrst) begin
            mem[waddr] <= wdata;
        end
    end

    // Read side mirrors the write side against the synchronized write pointer.
    assign ren         = rinc & ~rempty;
    assign rbin_next   = rbin + PW'(ren);
    assign rgray_next  = PW'(bin2gray(PTR_MAX'(rbin_next)));
    assign raddr       = rbin[ASIZE-1:0];
    assign rempty_next = (rgray_next == rq_wptr);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            rbin   <= '0;
            rgray  <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbin_next;
            rgray  <= rgray_next;
            rempty <= rempty_next;
        end
    end

    assign rdata = mem[raddr];

    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk (wclk),
        .rst (wrst),
        .d   (rgray),
        .q   (wq_rptr)
    );

    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk (wclk),
        .rst (wrst),
        .d   (wgray),
        .q   (rq_wptr)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: directed stimulus, queue-based data checks, occupancy model for flags.
module tb_async_fifo;

    localparam int DSIZE = 8;
    localparam int ASIZE = 3;
    localparam int SYNC  = 2;
    localparam int DEPTH = 8;

    logic             wclk = 1'b0;
    logic             wrst = 1'b1;
    logic             winc = 1'b0;
    logic [DSIZE-1:0] wdata = '0;
    logic             rinc = 1'b0;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    logic [DSIZE-1:0] exp_q [$];

    // Occupancy model: unbounded counts plus delayed copies for the crossing latency.
    int wp = 0;
    int rp = 0;
    int wsync [SYNC];
    int rsync [SYNC];
    bit m_full  = 1'b0;
    bit m_empty = 1'b1;

    async_fifo #(
        .DSIZE       (DSIZE),
        .ASIZE       (ASIZE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .wclk   (wclk),
        .wrst   (wrst),
        .winc   (winc),
        .wdata  (wdata),
        .rinc   (rinc),
        .rdata  (rdata),
        .wfull  (wfull),
        .rempty (rempty)
    );

    always #5 wclk = ~wclk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge wclk) begin
        int wp_n;
        int rp_n;
        if (wrst) begin
            wp = 0;
            rp = 0;
            for (int i = 0; i < SYNC; i++) begin
                wsync[i] = 0;
                rsync[i] = 0;
            end
            m_full  = 1'b0;
            m_empty = 1'b1;
            exp_q.delete();
        end else begin
            wp_n    = wp + ((winc && !m_full) ? 1 : 0);
            rp_n    = rp + ((rinc && !m_empty) ? 1 : 0);
            m_empty = (rp_n == wsync[SYNC-1]);
            m_full  = ((wp_n - rsync[SYNC-1]) == DEPTH);
            for (int i = SYNC - 1; i > 0; i--) begin
                wsync[i] = wsync[i-1];
                rsync[i] = rsync[i-1];
            end
            wsync[0] = wp;
            rsync[0] = rp;
            wp = wp_n;
            rp = rp_n;
        end
    end

    // Monitor: mid-cycle, compare flags and pop the scoreboard on every accepted read.
    always @(negedge wclk) begin
        if (armed) begin
            check_output("rempty_model", 32'(rempty), 32'(m_empty));
            check_output("wfull_model", 32'(wfull), 32'(m_full));
            check_output("occupancy_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
            if (rinc && !rempty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL read_underflow: actual=rdata %0d expected=no read while empty at %0t", rdata, $time);
                end else begin
                    check_output("rdata_order", 32'(rdata), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic apply_stimulus(input logic wi, input logic [DSIZE-1:0] wd, input logic ri);
        winc  = wi;
        wdata = wd;
        rinc  = ri;
        if (wi && !m_full) exp_q.push_back(wd);
        @(posedge wclk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    task automatic do_reset(input int edges);
        winc = 1'b0;
        rinc = 1'b0;
        wrst = 1'b1;
        repeat (edges) @(posedge wclk);
        #1;
        wrst = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            apply_stimulus(1'b0, '0, 1'b1);
        end
        check_output(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset and idle
        do_reset(2);
        armed = 1'b1;
        check_output("reset_rempty", 32'(rempty), 32'd1);
        check_output("reset_wfull", 32'(wfull), 32'd0);
        repeat (2) apply_stimulus(1'b0, '0, 1'b0);
        check_output("idle_rempty", 32'(rempty), 32'd1);
        check_output("idle_wfull", 32'(wfull), 32'd0);

        // Single write: rempty falls three edges after the write
        apply_stimulus(1'b1, 8'd10, 1'b0);
        check_output("single_rempty_t0", 32'(rempty), 32'd1);
        apply_stimulus(1'b0, '0, 1'b0);
        check_output("single_rempty_t1", 32'(rempty), 32'd1);
        apply_stimulus(1'b0, '0, 1'b0);
        check_output("single_rempty_t2", 32'(rempty), 32'd1);
        apply_stimulus(1'b0, '0, 1'b0);
        check_output("single_rempty_t3", 32'(rempty), 32'd0);
        check_output("single_rdata", 32'(rdata), 32'd10);
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("single_read_rempty", 32'(rempty), 32'd1);

        // Fill to full, blocked ninth write, then drain in order
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 8'(10 + 20 * i), 1'b0);
            check_output("fill_wfull", 32'(wfull), (i == 7) ? 32'd1 : 32'd0);
        end
        apply_stimulus(1'b1, 8'd170, 1'b0);
        check_output("blocked_wfull", 32'(wfull), 32'd1);
        check_output("blocked_head", 32'(rdata), 32'd10);
        for (int i = 0; i < 8; i++) begin
            check_output("fill_rdata", 32'(rdata), 32'(10 + 20 * i));
            apply_stimulus(1'b0, '0, 1'b1);
            check_output("fill_wfull_drop", 32'(wfull), (i < 3) ? 32'd1 : 32'd0);
        end
        check_output("fill_empty_after", 32'(rempty), 32'd1);
        check_output("fill_queue_empty", 32'(exp_q.size()), 32'd0);

        // Interleaved writes and reads
        for (int i = 0; i < 12; i++) begin
            apply_stimulus((i % 2) == 0, 8'((i + 1) * 10), (i % 3) == 0);
        end
        drain("interleave_drain");
        repeat (3) apply_stimulus(1'b0, '0, 1'b0);

        // Simultaneous write and read with wrap-around
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'(200 + i), 1'b0);
        repeat (4) apply_stimulus(1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 8'(i + 1), 1'b1);
            check_output("simul_rempty", 32'(rempty), 32'd0);
            check_output("simul_wfull", 32'(wfull), 32'd0);
        end
        check_output("simul_head", 32'(rdata), 32'd17);
        drain("simul_drain");
        repeat (3) apply_stimulus(1'b0, '0, 1'b0);

        // Mid-operation reset discards contents and rewinds pointers
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'(61 + i), 1'b0);
        repeat (3) apply_stimulus(1'b0, '0, 1'b0);
        check_output("pre_reset_rempty", 32'(rempty), 32'd0);
        do_reset(1);
        check_output("midreset_rempty", 32'(rempty), 32'd1);
        check_output("midreset_wfull", 32'(wfull), 32'd0);
        apply_stimulus(1'b1, 8'd77, 1'b0);
        apply_stimulus(1'b1, 8'd88, 1'b0);
        repeat (3) apply_stimulus(1'b0, '0, 1'b0);
        check_output("midreset_entry0", 32'(rdata), 32'd77);
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("midreset_entry1", 32'(rdata), 32'd88);
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("midreset_final_empty", 32'(rempty), 32'd1);
        repeat (4) apply_stimulus(1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
